// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared encodings and sizes for the mux4 scan sequencer
package mux4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int CH_W        = 2;
    localparam int NUM_CH      = 4;
    localparam int SETTLE_DEF  = 2;

endpackage

// File: rtl/dwell_cnt.sv
// rtl/dwell_cnt.sv - clear/enable dwell counter with terminal count at SETTLE-1
module dwell_cnt #(
    parameter int SETTLE   = 2,
    parameter int SETTLE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - 4:1 combinational mux driven by the scan sequencer selects
module mux4_1 (
    input  logic [3:0] d,
    input  logic       s1,
    input  logic       s0,
    output logic       y
);

    assign y = d[{s1, s0}];

endmodule

// File: rtl/mux4_scan_ctrl.sv
// rtl/mux4_scan_ctrl.sv - steps mux4_1 selects, samples y per channel, hands 4-bit frames downstream
module mux4_scan_ctrl
    import mux4_pkg::*;
#(
    parameter int SETTLE   = SETTLE_DEF,
    parameter int SETTLE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun
);

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [2:0]      shadow_q, shadow_d;
    logic [3:0]      frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            overrun_q, overrun_d;

    logic            tc;
    logic            start_acc;
    logic            sample;
    logic            frame_done;

    dwell_cnt #(
        .SETTLE   (SETTLE),
        .SETTLE_W (SETTLE_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc | sample),
        .en    (state_q == ST_SCAN),
        .tc    (tc)
    );

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        start_acc     = 1'b0;
        sample        = 1'b0;
        frame_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    ch_d      = '0;
                    overrun_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (tc) begin
                    sample = 1'b1;
                    if (ch_q != CH_W'(NUM_CH - 1)) begin
                        shadow_d[ch_q] = y;
                        ch_d           = ch_q + 1'b1;
                    end else begin
                        frame_d    = {y, shadow_q};
                        frame_done = 1'b1;
                        ch_d       = '0;
                        if (!continuous) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new frame wins over an accept; it only counts as overrun if the old one was not taken.
        if (frame_done) begin
            frame_valid_d = 1'b1;
            if (frame_valid_q && !frame_ready) begin
                overrun_d = 1'b1;
            end
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign s1          = ch_q[1];
    assign s0          = ch_q[0];
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q == ST_SCAN);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb/tb_mux4_scan_ctrl.sv - directed bench for mux4_scan_ctrl driving real mux4_1 instances
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start, continuous, frame_ready;
    logic [3:0] mux_d;
    logic       y, s0, s1, frame_valid, busy, overrun;
    logic [3:0] frame;

    logic       start1, frame_ready1;
    logic [3:0] mux1_d;
    logic       y1, s0_1, s1_1, frame_valid1, busy1, overrun1;
    logic [3:0] frame1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4_1 u_mux (.d(mux_d), .s1(s1), .s0(s0), .y(y));

    mux4_scan_ctrl #(.SETTLE(2), .SETTLE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .y           (y),
        .s0          (s0),
        .s1          (s1),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    mux4_1 u_mux1 (.d(mux1_d), .s1(s1_1), .s0(s0_1), .y(y1));

    mux4_scan_ctrl #(.SETTLE(1), .SETTLE_W(4)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .continuous  (1'b0),
        .y           (y1),
        .s0          (s0_1),
        .s1          (s1_1),
        .frame       (frame1),
        .frame_valid (frame_valid1),
        .frame_ready (frame_ready1),
        .busy        (busy1),
        .overrun     (overrun1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        continuous   = 1'b0;
        frame_ready  = 1'b0;
        mux_d        = 4'b0000;
        start1       = 1'b0;
        frame_ready1 = 1'b0;
        mux1_d       = 4'b0000;
        tick();
        tick();
        chk("rst_sel",     {6'd0, s1, s0}, 8'd0);
        chk("rst_valid",   {7'd0, frame_valid}, 8'd0);
        chk("rst_busy",    {7'd0, busy}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        chk("rst_frame",   {4'd0, frame}, 8'd0);
        rst_n = 1'b1;
        tick();

        // T1: asynchronous reset in the middle of a scan
        mux_d = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t1_sel_ch2", {6'd0, s1, s0}, 8'd2);
        rst_n = 1'b0;
        #1;
        chk("t1_async_sel",   {6'd0, s1, s0}, 8'd0);
        chk("t1_async_valid", {7'd0, frame_valid}, 8'd0);
        chk("t1_async_busy",  {7'd0, busy}, 8'd0);
        chk("t1_async_ovr",   {7'd0, overrun}, 8'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t1_idle_busy",  {7'd0, busy}, 8'd0);
        chk("t1_idle_sel",   {6'd0, s1, s0}, 8'd0);
        chk("t1_idle_valid", {7'd0, frame_valid}, 8'd0);

        // T2: single shot, ch0..3 data = 1,0,1,1
        mux_d = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_busy", {7'd0, busy}, 8'd1);
        chk("t2_sel_0", {6'd0, s1, s0}, 8'd0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t2_sel_%0d", k), {6'd0, s1, s0}, 8'(k / 2));
            chk($sformatf("t2_nvalid_%0d", k), {7'd0, frame_valid}, 8'd0);
        end
        tick();
        chk("t2_frame", {4'd0, frame}, 8'b0000_1101);
        chk("t2_valid", {7'd0, frame_valid}, 8'd1);
        chk("t2_busy_fall", {7'd0, busy}, 8'd0);
        chk("t2_sel_home", {6'd0, s1, s0}, 8'd0);

        // T3: backpressure then a single accept
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("t3_hold_%0d", k), {3'd0, frame_valid, frame}, 8'b0001_1101);
        end
        frame_ready = 1'b1;
        tick();
        chk("t3_accept_valid", {7'd0, frame_valid}, 8'd0);
        chk("t3_accept_frame", {4'd0, frame}, 8'b0000_1101);
        tick();
        chk("t3_ready_no_valid", {7'd0, frame_valid}, 8'd0);
        frame_ready = 1'b0;

        // T4: continuous with no consumer -> overrun
        continuous = 1'b1;
        mux_d = 4'b0110;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_ovr_start", {7'd0, overrun}, 8'd0);
        repeat (8) tick();
        chk("t4_frame1", {4'd0, frame}, 8'b0000_0110);
        chk("t4_valid1", {7'd0, frame_valid}, 8'd1);
        chk("t4_ovr1",   {7'd0, overrun}, 8'd0);
        chk("t4_busy1",  {7'd0, busy}, 8'd1);
        mux_d = 4'b1001;
        repeat (8) tick();
        chk("t4_frame2", {4'd0, frame}, 8'b0000_1001);
        chk("t4_ovr2",   {7'd0, overrun}, 8'd1);
        chk("t4_busy2",  {7'd0, busy}, 8'd1);
        continuous = 1'b0;
        repeat (8) tick();
        chk("t4_busy3",  {7'd0, busy}, 8'd0);
        chk("t4_ovr3",   {7'd0, overrun}, 8'd1);
        repeat (3) tick();
        chk("t4_ovr_sticky", {7'd0, overrun}, 8'd1);

        // T5: accept on the completion edge of the next frame
        continuous = 1'b1;
        mux_d = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_ovr_cleared", {7'd0, overrun}, 8'd0);
        repeat (7) tick();
        chk("t5_old_pending", {3'd0, frame_valid, frame}, 8'b0001_1001);
        frame_ready = 1'b1;
        tick();
        chk("t5_new_frame", {3'd0, frame_valid, frame}, 8'b0001_0011);
        chk("t5_no_ovr", {7'd0, overrun}, 8'd0);
        chk("t5_busy", {7'd0, busy}, 8'd1);
        continuous = 1'b0;
        tick();
        chk("t5_accepted", {7'd0, frame_valid}, 8'd0);
        frame_ready = 1'b0;
        repeat (7) tick();
        chk("t5_last_frame", {3'd0, frame_valid, frame}, 8'b0001_0011);
        chk("t5_last_ovr", {7'd0, overrun}, 8'd0);
        chk("t5_last_busy", {7'd0, busy}, 8'd0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("t5_drain", {7'd0, frame_valid}, 8'd0);

        // T6: start pulses while scanning are ignored
        mux_d = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_sel_ch2", {6'd0, s1, s0}, 8'd2);
        chk("t6_busy", {7'd0, busy}, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_pre_valid", {7'd0, frame_valid}, 8'd0);
        chk("t6_pre_sel", {6'd0, s1, s0}, 8'd3);
        tick();
        chk("t6_frame", {3'd0, frame_valid, frame}, 8'b0001_1010);
        chk("t6_done_busy", {7'd0, busy}, 8'd0);

        // T6b: SETTLE=1 frame lands 4 cycles after start
        mux1_d = 4'b0101;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t6b_busy", {7'd0, busy1}, 8'd1);
        chk("t6b_sel0", {6'd0, s1_1, s0_1}, 8'd0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t6b_sel1", {6'd0, s1_1, s0_1}, 8'd1);
        tick();
        tick();
        chk("t6b_pre_valid", {7'd0, frame_valid1}, 8'd0);
        chk("t6b_sel3", {6'd0, s1_1, s0_1}, 8'd3);
        tick();
        chk("t6b_frame", {3'd0, frame_valid1, frame1}, 8'b0001_0101);
        chk("t6b_busy_fall", {7'd0, busy1}, 8'd0);
        chk("t6b_ovr", {7'd0, overrun1}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
